// File: rtl/a51_stream_decrypt_if.sv
// ---------------------------------------------------------------------------
// a51_stream_decrypt_if
// Ciphertext-in / plaintext-out nibble streams of the A5/1 stream decryptor.
//   ct_valid, ct_nibble : upstream ciphertext nibble and its valid
//   ct_ready            : decryptor accepts ct_nibble this cycle
//   pt_valid, pt_nibble : plaintext nibble and its valid
//   pt_ready            : downstream accepts pt_nibble
// master : the stream environment (ciphertext source, plaintext sink)
// slave  : the decryptor
// ---------------------------------------------------------------------------
interface a51_stream_decrypt_if;
    logic       ct_valid;
    logic [3:0] ct_nibble;
    logic       ct_ready;
    logic       pt_valid;
    logic [3:0] pt_nibble;
    logic       pt_ready;

    modport master (
        output ct_valid, ct_nibble, pt_ready,
        input  ct_ready, pt_valid, pt_nibble
    );

    modport slave (
        input  ct_valid, ct_nibble, pt_ready,
        output ct_ready, pt_valid, pt_nibble
    );
endinterface

// File: rtl/a51_stream_decrypt.sv
// ---------------------------------------------------------------------------
// a51_stream_decrypt
// Collects 128 keystream bits from an A5/1 keygen, then decrypts a frame of
// 32 ciphertext nibbles by XOR with the captured keystream.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   start         : one-cycle frame request (honoured in IDLE/DONE only)
//   ks_bit        : serial keystream bit
//   ks_ready      : ks_bit valid
//   ks_depleted   : keygen has run out of keystream
//   ks_start      : enable to keygen, high exactly while collecting
//   bus (slave)   : ct/pt nibble streams, see a51_stream_decrypt_if
//   nibble_count  : plaintext nibbles delivered this frame (0..32)
//   busy          : FSM is in GEN, XOR or ERR
//   done          : frame complete, held until next start or reset
//   error         : sticky keystream fault, cleared only by reset
//
// Build option
//   A51_DEC_PIPE_EN : defined   -> one-entry registered XOR output stage
//                     undefined -> combinational pass-through (default)
//
// state | meaning
// IDLE  | waiting for start
// GEN   | keygen enabled, capturing 128 keystream bits
// XOR   | decrypting 32 nibbles
// DONE  | frame complete, waiting for start
// ERR   | keystream fault (watchdog or early depletion), reset only
// ---------------------------------------------------------------------------
module a51_stream_decrypt (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       ks_bit,
    input  logic                       ks_ready,
    input  logic                       ks_depleted,
    output logic                       ks_start,
    a51_stream_decrypt_if.slave        bus,
    output logic [5:0]                 nibble_count,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [2:0] {IDLE, GEN, XOR, DONE, ERR} state_t;

    state_t       state;
    logic [127:0] ks_buf;
    logic [7:0]   bit_cnt;
    logic [9:0]   wdog;
    logic [4:0]   ks_idx;
    logic [3:0]   ks_nibble;
    logic         in_xor;
    logic         xfer;

    assign in_xor = (state == XOR);

    // First captured bit of each group of four is the nibble MSB.
    assign ks_nibble = {ks_buf[{ks_idx, 2'd0}], ks_buf[{ks_idx, 2'd1}],
                        ks_buf[{ks_idx, 2'd2}], ks_buf[{ks_idx, 2'd3}]};

`ifdef A51_DEC_PIPE_EN
    logic [5:0] acc_cnt;
    logic       pv;
    logic [3:0] pn;
    logic       accept;

    // The keystream index follows acceptances, which run one ahead of
    // deliveries while the output register is occupied.
    assign ks_idx        = acc_cnt[4:0];
    assign bus.ct_ready  = in_xor & (~pv | bus.pt_ready) & ~acc_cnt[5];
    assign bus.pt_valid  = in_xor & pv;
    assign bus.pt_nibble = in_xor ? pn : 4'h0;
    assign accept        = bus.ct_valid & bus.ct_ready;
    assign xfer          = bus.pt_valid & bus.pt_ready;
`else
    assign ks_idx        = nibble_count[4:0];
    assign bus.ct_ready  = in_xor & bus.pt_ready;
    assign bus.pt_valid  = in_xor & bus.ct_valid;
    assign bus.pt_nibble = in_xor ? (bus.ct_nibble ^ ks_nibble) : 4'h0;
    assign xfer          = bus.pt_valid & bus.pt_ready;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ks_buf       <= '0;
            bit_cnt      <= '0;
            wdog         <= '0;
            nibble_count <= '0;
            ks_start     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef A51_DEC_PIPE_EN
            acc_cnt      <= '0;
            pv           <= 1'b0;
            pn           <= 4'h0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= GEN;
                        ks_start     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        bit_cnt      <= '0;
                        wdog         <= '0;
                        nibble_count <= '0;
`ifdef A51_DEC_PIPE_EN
                        acc_cnt      <= '0;
`endif
                    end
                end
                GEN: begin
                    wdog <= wdog + 10'd1;
                    if (ks_ready) begin
                        ks_buf[bit_cnt[6:0]] <= ks_bit;
                        bit_cnt              <= bit_cnt + 8'd1;
                    end
                    // Completing the buffer wins over a same-cycle fault.
                    // wdog==510 here means it reaches 511 on this edge.
                    if (ks_ready && bit_cnt == 8'd127) begin
                        state    <= XOR;
                        ks_start <= 1'b0;
                    end else if (ks_depleted || wdog == 10'd510) begin
                        state    <= ERR;
                        ks_start <= 1'b0;
                        error    <= 1'b1;
                    end
                end
                XOR: begin
`ifdef A51_DEC_PIPE_EN
                    if (accept) begin
                        pn      <= bus.ct_nibble ^ ks_nibble;
                        pv      <= 1'b1;
                        acc_cnt <= acc_cnt + 6'd1;
                    end else if (xfer) begin
                        pv <= 1'b0;
                    end
`endif
                    if (xfer) begin
                        nibble_count <= nibble_count + 6'd1;
                        if (nibble_count == 6'd31) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a51_stream_decrypt.sv
module tb_a51_stream_decrypt;

    logic       clk = 1'b0;
    logic       reset, start, ks_bit, ks_ready, ks_depleted;
    logic       ks_start, busy, done, error;
    logic [5:0] nibble_count;

    a51_stream_decrypt_if bus ();

    a51_stream_decrypt dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ks_bit       (ks_bit),
        .ks_ready     (ks_ready),
        .ks_depleted  (ks_depleted),
        .ks_start     (ks_start),
        .bus          (bus.slave),
        .nibble_count (nibble_count),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [3:0] exp_q[$];
    int         xfers = 0;
    int         stall_at = -1;
    int         stall_left = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_nib = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-derived keystream patterns.
    function automatic logic ks_bit_of(input int mode, input int j);
        logic [3:0] v;
        v = 4'(j / 4);
        case (mode)
            0:       return 1'b1;
            1:       return (j % 4) == 0;
            default: return v[3 - (j % 4)];
        endcase
    endfunction

    function automatic logic [3:0] ks_nib_of(input int mode, input int n);
        case (mode)
            0:       return 4'hF;
            1:       return 4'h8;
            default: return 4'(n);
        endcase
    endfunction

    function automatic logic [3:0] ct_of(input int mode, input int i);
        case (mode)
            0:       return 4'h5;
            1:       return 4'h0;
            default: return 4'hC;
        endcase
    endfunction

    // Scoreboard monitor: pops an expectation on every plaintext transfer.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid_held", 32'(bus.pt_valid), 32'd1);
            chk("stall_nibble_held", 32'(bus.pt_nibble), 32'(prev_nib));
        end
        prev_stall = bus.pt_valid && !bus.pt_ready;
        prev_nib   = bus.pt_nibble;
        if (bus.pt_valid && bus.pt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pt_unexpected actual=%0h expected=none", bus.pt_nibble);
            end else begin
                chk("pt_nibble", 32'(bus.pt_nibble), 32'(exp_q.pop_front()));
            end
            xfers++;
        end
    end

    // Downstream ready, with an optional stall while nibble stall_at is pending.
    initial begin
        bus.pt_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && xfers == stall_at) begin
                bus.pt_ready = 1'b0;
                stall_left--;
            end else begin
                bus.pt_ready = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ks_start"}, 32'(ks_start), 32'd0);
        chk({tag, "_ct_ready"}, 32'(bus.ct_ready), 32'd0);
        chk({tag, "_pt_valid"}, 32'(bus.pt_valid), 32'd0);
        chk({tag, "_pt_nibble"}, 32'(bus.pt_nibble), 32'd0);
        chk({tag, "_nibble_count"}, 32'(nibble_count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic feed_ks(input int mode, input bit toggle, input bit midstart, output int gen);
        int  j = 0;
        int  guard = 0;
        logic rdy;
        gen = 0;
        while (j < 128 && guard < 1500) begin
            start = 1'b0;
            if (ks_start) begin
                gen++;
                rdy = toggle ? (gen % 2 == 0) : 1'b1;
                ks_ready = rdy;
                // Discarded cycles carry the inverted bit so a capture would show.
                ks_bit = rdy ? ks_bit_of(mode, j) : ~ks_bit_of(mode, j);
                if (rdy) j++;
                if (midstart && gen == 50) start = 1'b1;
            end
            tick();
            guard++;
        end
        start = 1'b0;
        ks_ready = 1'b0;
        if (guard >= 1500) begin
            total++;
            bad++;
            $display("FAIL ks_feed_timeout actual=%0d bits required=128", j);
        end
    endtask

    task automatic drive_ct(input int ksmode, input int ctmode, input int n);
        int i = 0;
        int guard = 0;
        logic acc;
        bus.ct_valid  = 1'b1;
        bus.ct_nibble = ct_of(ctmode, 0);
        exp_q.push_back(ct_of(ctmode, 0) ^ ks_nib_of(ksmode, 0));
        while (i < n && guard < 3000) begin
            @(negedge clk);
            acc = bus.ct_valid && bus.ct_ready;
            tick();
            guard++;
            if (acc) begin
                i++;
                if (i < n) begin
                    bus.ct_nibble = ct_of(ctmode, i);
                    exp_q.push_back(ct_of(ctmode, i) ^ ks_nib_of(ksmode, i));
                end else begin
                    bus.ct_valid = 1'b0;
                end
            end
        end
        bus.ct_valid = 1'b0;
        if (guard >= 3000) begin
            total++;
            bad++;
            $display("FAIL ct_accept_timeout actual=%0d required=%0d", i, n);
        end
    endtask

    task automatic run_frame(input string tag, input int ksmode, input int ctmode, input bit toggle,
                             input int stall, input bit midstart, input int n);
        int gen;
        int w = 0;
        xfers      = 0;
        stall_at   = stall;
        stall_left = (stall >= 0) ? 3 : 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_start_count_clr"}, 32'(nibble_count), 32'd0);
        chk({tag, "_start_busy"}, 32'(busy), 32'd1);
        chk({tag, "_start_ks_start"}, 32'(ks_start), 32'd1);
        fork
            feed_ks(ksmode, toggle, midstart, gen);
            drive_ct(ksmode, ctmode, n);
        join
        chk({tag, "_gen_cycles"}, 32'(gen), toggle ? 32'd256 : 32'd128);
        if (n == 32) begin
            while (!done && w < 20) begin
                tick();
                w++;
            end
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_nibble_count"}, 32'(nibble_count), 32'd32);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
            chk({tag, "_ks_start"}, 32'(ks_start), 32'd0);
            chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
            chk({tag, "_xfers"}, 32'(xfers), 32'd32);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; ks_bit = 1'b0; ks_ready = 1'b0; ks_depleted = 1'b0;
        bus.ct_valid = 1'b0; bus.ct_nibble = 4'h0;
        tick(); tick();
        check_idle_zero("reset");
        reset = 1'b0;
        tick();

        // All-ones keystream, ct 5 -> A.
        run_frame("ones", 0, 0, 1'b0, -1, 1'b0, 32);
        // 1000 keystream, ct 0 -> 8, ks_ready toggling; started from DONE.
        run_frame("toggle", 1, 1, 1'b1, -1, 1'b0, 32);
        // Counting keystream, ct C, 3-cycle stall at nibble 7, start pulsed mid-GEN.
        run_frame("stall", 2, 2, 1'b0, 7, 1'b1, 32);

        // Reset in the middle of XOR, then a clean frame.
        run_frame("abort", 0, 2, 1'b0, -1, 1'b0, 10);
        reset = 1'b1;
        tick();
        check_idle_zero("midxor_reset");
        reset = 1'b0;
        exp_q.delete();
        tick();
        run_frame("after_reset", 2, 1, 1'b0, -1, 1'b0, 32);

        // Watchdog: no keystream at all; a start during GEN must not restart it.
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (ks_start && cnt < 600) begin
            cnt++;
            start = (cnt == 100);
            tick();
        end
        start = 1'b0;
        chk("wdog_gen_cycles", 32'(cnt), 32'd511);
        chk("wdog_error", 32'(error), 32'd1);
        chk("wdog_ks_start", 32'(ks_start), 32'd0);
        chk("wdog_busy", 32'(busy), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("err_start_ignored_ks", 32'(ks_start), 32'd0);
        chk("err_sticky", 32'(error), 32'd1);
        chk("err_no_done", 32'(done), 32'd0);
        reset = 1'b1;
        tick();
        check_idle_zero("err_reset");
        reset = 1'b0;
        tick();

        // Keygen depleted before 128 bits.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ks_ready = 1'b1;
            ks_bit = 1'b1;
            tick();
        end
        ks_ready = 1'b0;
        chk("depl_pre_error", 32'(error), 32'd0);
        ks_depleted = 1'b1;
        tick();
        ks_depleted = 1'b0;
        chk("depl_error", 32'(error), 32'd1);
        chk("depl_ks_start", 32'(ks_start), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a51_stream_decrypt.md
A51_STREAM_DECRYPT -- requirements
Module: a51_stream_decrypt

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: one-cycle request to begin a frame.
REQ-004 SHALL have port ks_bit, input, 1: serial keystream bit from a51_keygen a51out.
REQ-005 SHALL have port ks_ready, input, 1: keystream bit valid, from KeyStreamReady.
REQ-006 SHALL have port ks_depleted, input, 1: keygen done, from KeyStreamDepleted.
REQ-007 SHALL have port ks_start, output, 1: level enable to keygen startKeyStreamGen.
REQ-008 SHALL have port ct_valid, input, 1: ciphertext nibble valid.
REQ-009 SHALL have port ct_nibble, input, 4: ciphertext nibble.
REQ-010 SHALL have port ct_ready, output, 1: block accepts ct_nibble this cycle.
REQ-011 SHALL have port pt_valid, output, 1: plaintext nibble valid.
REQ-012 SHALL have port pt_nibble, output, 4: plaintext nibble.
REQ-013 SHALL have port pt_ready, input, 1: downstream accepts pt_nibble.
REQ-014 SHALL have port nibble_count, output, 6: plaintext nibbles delivered, 0..32.
REQ-015 SHALL have port busy, output, 1: state is not IDLE or DONE.
REQ-016 SHALL have port done, output, 1: 32 nibbles delivered.
REQ-017 SHALL have port error, output, 1: sticky keystream fault.

Function
REQ-018 SHALL use FSM states IDLE, GEN, XOR, DONE, ERR.
REQ-019 IDLE/DONE: start=1 SHALL go to GEN, clear bit, nibble and watchdog counters, and clear done.
REQ-020 In GEN, XOR and ERR, start SHALL be ignored.
REQ-021 ks_start SHALL be 1 exactly while in GEN.
REQ-022 GEN: each cycle with ks_ready=1 SHALL capture ks_bit into a 128-bit buffer at index bit_cnt, then increment the 8-bit bit_cnt.
REQ-023 Bits with ks_ready=0 SHALL be discarded.
REQ-024 Capture of bit 127 SHALL move the FSM to XOR on the next edge.
REQ-025 Keystream nibble n SHALL be {buf[4n], buf[4n+1], buf[4n+2], buf[4n+3]}; first captured bit is the MSB.
REQ-026 XOR: pt_nibble SHALL equal ct_nibble XOR keystream nibble n, where n = nibble_count[4:0].
REQ-027 Transfer SHALL occur on pt_valid & pt_ready; each transfer SHALL increment nibble_count.
REQ-028 The transfer making nibble_count 32 SHALL move the FSM to DONE; done=1 SHALL hold until start or reset.
REQ-029 Outside XOR, ct_ready and pt_valid SHALL be 0 and pt_nibble SHALL be 4'h0.
REQ-030 GEN watchdog: 10-bit counter from 0 at GEN entry; reaching 511 with bit_cnt<128 SHALL go to ERR.
REQ-031 GEN: ks_depleted=1 with bit_cnt<128 SHALL go to ERR.
REQ-032 ERR SHALL set error=1, keep ks_start=0, and be left only by reset.
REQ-033 ct_valid outside XOR SHALL have no effect.

Reset
REQ-034 reset=1 SHALL, on that edge, force IDLE regardless of state, including mid-GEN and mid-XOR.
REQ-035 Reset SHALL set these outputs to 0: ks_start, ct_ready, pt_valid, pt_nibble, nibble_count, busy, done, error.
REQ-036 Reset SHALL clear the keystream buffer, bit_cnt and watchdog.
REQ-037 reset SHALL take priority over start.

Configuration
REQ-038 Macro A51_DEC_PIPE_EN SHALL select the XOR output stage.
REQ-039 Macro undefined: combinational pass-through; pt_valid=ct_valid, ct_ready=pt_ready, zero latency.
REQ-040 Macro defined: one-entry registered stage; ct_ready = ~pt_valid | pt_ready.
REQ-041 Macro defined: pt_nibble SHALL appear one cycle after acceptance, full throughput with pt_ready=1.
REQ-042 Macro defined: the stage SHALL stop accepting after the 32nd acceptance.
REQ-043 Macro defined: DONE SHALL be entered after the 32nd output transfer.

Verification
REQ-044 All-ones keystream over 128 ks_ready cycles, ct_nibble=4'h5 x32, pt_ready=1 -> pt_nibble=4'hA x32, then done=1 and nibble_count=32.
REQ-045 Keystream pattern 1,0,0,0 repeated, ct_nibble=4'h0 -> every pt_nibble=4'h8; ks_ready toggled 1/0 -> same result, 256 GEN cycles.
REQ-046 pt_ready low 3 cycles at nibble 7 -> pt_nibble held stable, no loss or duplication, nibble_count=32 at end.
REQ-047 ks_ready never asserted after start -> ERR after 511 GEN cycles, error=1, ks_start=0; start ignored; reset clears error.
REQ-048 reset at nibble 10 of XOR -> next cycle all outputs 0, IDLE; new start yields a correct full frame.
REQ-049 start pulsed mid-GEN -> ignored, frame unaffected; start in DONE -> new frame, done cleared.
